// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and parity-sense constants,
// common to the receiver and transmitter generations.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_t;

    localparam logic PARITY_SENSE_EVEN = 1'b0;
    localparam logic PARITY_SENSE_ODD  = 1'b1;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for asynchronous inputs; both stages preset high on reset
// so an idle-high line never looks active while reset releases.
module uart_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_s1;
    logic r_s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= 1'b1;
            r_s2 <= 1'b1;
        end else begin
            r_s1 <= i_d;
            r_s2 <= r_s1;
        end
    end

    assign o_q = r_s2;

endmodule

// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver: configurable baud divisor, data width, parity and stop
// bits, with start-glitch rejection, framing/parity/overrun flags and break handling.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int unsigned BAUD_DIV   = 34,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 RX,
    input  logic                 clr_rdy,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rdy,
    output logic                 frm_err,
    output logic                 par_err,
    output logic                 ovr_err
);

    localparam int unsigned CW = $clog2(BAUD_DIV);
    localparam int unsigned BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] HALF_LOAD = CW'(BAUD_DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(BAUD_DIV - 1);
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
    localparam logic ODD_BIT = (PARITY_ODD != 0) ? PARITY_SENSE_ODD : PARITY_SENSE_EVEN;

    logic                 w_rx_s;
    logic                 w_strobe;
    rx_state_t            r_state;
    logic [CW-1:0]        r_cnt;
    logic [BW-1:0]        r_bitcnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_bad;
    logic                 r_stop_bad;
    logic                 r_commit;

    uart_sync2 u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (RX),
        .o_q   (w_rx_s)
    );

    assign w_strobe = (r_state != IDLE) && (r_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (r_state == IDLE) begin
            if (!w_rx_s) r_cnt <= HALF_LOAD;
        end else if (w_strobe) begin
            r_cnt <= FULL_LOAD;
        end else begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_bitcnt   <= '0;
            r_shift    <= '0;
            r_par_bad  <= 1'b0;
            r_stop_bad <= 1'b0;
            r_commit   <= 1'b0;
            rx_data    <= '0;
            rdy        <= 1'b0;
            frm_err    <= 1'b0;
            par_err    <= 1'b0;
            ovr_err    <= 1'b0;
        end else begin
            if (clr_rdy) begin
                rdy     <= 1'b0;
                frm_err <= 1'b0;
                par_err <= 1'b0;
                ovr_err <= 1'b0;
            end
            case (r_state)
                IDLE: if (!w_rx_s) r_state <= START;
                START: if (w_strobe) begin
                    r_bitcnt   <= '0;
                    r_par_bad  <= 1'b0;
                    r_stop_bad <= 1'b0;
                    r_state    <= w_rx_s ? IDLE : DATA;
                end
                DATA: if (w_strobe) begin
                    r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
                    if (r_bitcnt == LAST_DATA) begin
                        r_bitcnt <= '0;
                        r_state  <= (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        r_bitcnt <= r_bitcnt + BW'(1);
                    end
                end
                PARITY: if (w_strobe) begin
                    r_par_bad <= (^r_shift) ^ w_rx_s ^ ODD_BIT;
                    r_state   <= STOP;
                end
                // Commit lands one cycle after the last stop strobe; it overrides a
                // simultaneous clr_rdy, which only serves to acknowledge the old frame.
                STOP: if (r_commit) begin
                    r_commit <= 1'b0;
                    rx_data  <= r_shift;
                    rdy      <= 1'b1;
                    frm_err  <= r_stop_bad;
                    par_err  <= r_par_bad;
                    ovr_err  <= !clr_rdy && (ovr_err || rdy);
                    r_state  <= w_rx_s ? IDLE : BREAK;
                end else if (w_strobe) begin
                    if (!w_rx_s) r_stop_bad <= 1'b1;
                    if (r_bitcnt == LAST_STOP) r_commit <= 1'b1;
                    else r_bitcnt <= r_bitcnt + BW'(1);
                end
                BREAK: if (w_rx_s) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: three configurations driven by directed and random frames,
// checked against a frame-level reference model.
module tb_uart_rx_cfg;

    logic       clk;
    logic       rst_n;
    logic [2:0] rx;
    logic [2:0] clr;
    logic [7:0] d_a;
    logic [6:0] d_b;
    logic [7:0] d_c;
    logic [2:0] rdyv, frmv, parv, ovrv;

    int total = 0;
    int bad   = 0;
    logic [2:0] rdy_m;
    logic [2:0] ovr_m;

    uart_rx_cfg u_a (
        .clk(clk), .rst_n(rst_n), .RX(rx[0]), .clr_rdy(clr[0]), .rx_data(d_a),
        .rdy(rdyv[0]), .frm_err(frmv[0]), .par_err(parv[0]), .ovr_err(ovrv[0])
    );

    uart_rx_cfg #(.BAUD_DIV(16), .DATA_BITS(7), .PARITY_EN(1), .PARITY_ODD(1)) u_b (
        .clk(clk), .rst_n(rst_n), .RX(rx[1]), .clr_rdy(clr[1]), .rx_data(d_b),
        .rdy(rdyv[1]), .frm_err(frmv[1]), .par_err(parv[1]), .ovr_err(ovrv[1])
    );

    uart_rx_cfg #(.BAUD_DIV(21), .STOP_BITS(2)) u_c (
        .clk(clk), .rst_n(rst_n), .RX(rx[2]), .clr_rdy(clr[2]), .rx_data(d_c),
        .rdy(rdyv[2]), .frm_err(frmv[2]), .par_err(parv[2]), .ovr_err(ovrv[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int bd_of(int i);
        return (i == 0) ? 34 : (i == 1) ? 16 : 21;
    endfunction
    function automatic int nb_of(int i);
        return (i == 1) ? 7 : 8;
    endfunction
    function automatic int pe_of(int i);
        return (i == 1) ? 1 : 0;
    endfunction
    function automatic int sb_of(int i);
        return (i == 2) ? 2 : 1;
    endfunction
    function automatic logic odd_of(int i);
        return (i == 1);
    endfunction
    function automatic logic [8:0] mask_of(int i);
        return 9'((1 << nb_of(i)) - 1);
    endfunction
    function automatic int lat_of(int i);
        return 2 + bd_of(i) / 2 + (nb_of(i) + pe_of(i) + sb_of(i)) * bd_of(i) + 1;
    endfunction
    // Parity bit a correct transmitter would send for these data bits.
    function automatic logic par_bit_of(int i, logic [8:0] d);
        return (^(d & mask_of(i))) ^ odd_of(i);
    endfunction
    function automatic logic [8:0] data_of(int i);
        return (i == 0) ? {1'b0, d_a} : (i == 1) ? {2'b0, d_b} : {1'b0, d_c};
    endfunction
    function automatic logic [3:0] flags_of(int i);
        return {rdyv[i], frmv[i], parv[i], ovrv[i]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic send_frame(input int i, input logic [8:0] d, input logic pbit,
                              input logic [1:0] stopv);
        rx[i] = 1'b0;
        repeat (bd_of(i)) @(negedge clk);
        for (int k = 0; k < nb_of(i); k++) begin
            rx[i] = d[k];
            repeat (bd_of(i)) @(negedge clk);
        end
        if (pe_of(i) != 0) begin
            rx[i] = pbit;
            repeat (bd_of(i)) @(negedge clk);
        end
        for (int k = 0; k < sb_of(i); k++) begin
            rx[i] = stopv[k];
            repeat (bd_of(i)) @(negedge clk);
        end
    endtask

    task automatic check_frame(input string tag, input int i, input logic [8:0] d,
                               input logic pbit, input logic [1:0] stopv);
        logic [8:0] dm;
        logic e_frm, e_par, e_ovr;
        dm    = d & mask_of(i);
        e_frm = !stopv[0] || (sb_of(i) == 2 && !stopv[1]);
        e_par = (pe_of(i) != 0) && (pbit != par_bit_of(i, dm));
        e_ovr = ovr_m[i] | rdy_m[i];
        rdy_m[i] = 1'b1;
        ovr_m[i] = e_ovr;
        check({tag, "_data"}, 32'(data_of(i)), 32'(dm));
        check({tag, "_flags"}, 32'(flags_of(i)), {28'd0, 1'b1, e_frm, e_par, e_ovr});
    endtask

    task automatic clr_pulse(input string tag, input int i);
        clr[i] = 1'b1;
        @(posedge clk);
        #1;
        check(tag, 32'(flags_of(i)), 32'd0);
        @(negedge clk);
        clr[i] = 1'b0;
        rdy_m[i] = 1'b0;
        ovr_m[i] = 1'b0;
    endtask

    initial begin
        logic [8:0] d;
        logic       pb;
        logic [1:0] sv;
        int         lat_seen;

        rst_n = 1'b0;
        rx    = '1;
        clr   = '0;
        rdy_m = '0;
        ovr_m = '0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("rst_flags", 32'(flags_of(i)), 32'd0);
            check("rst_data", 32'(data_of(i)), 32'd0);
        end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // 8N1 0xA5 with latency measured from the RX falling edge
        lat_seen = -1;
        fork
            send_frame(0, 9'h0A5, 1'b0, 2'b11);
            begin
                for (int e = 0; e < 2000 && lat_seen < 0; e++) begin
                    @(posedge clk);
                    #1;
                    if (rdyv[0]) lat_seen = e;
                end
            end
        join
        check("t1_latency", 32'(lat_seen), 32'(lat_of(0)));
        check_frame("t1", 0, 9'h0A5, 1'b0, 2'b11);
        clr_pulse("t1_clr", 0);

        // start-bit glitch shorter than half a bit period
        rx[0] = 1'b0;
        repeat (10) @(negedge clk);
        rx[0] = 1'b1;
        repeat (3 * bd_of(0)) @(negedge clk);
        check("t2_glitch", 32'(flags_of(0)), 32'd0);

        // 7O1: correct then wrong parity on 0x41
        pb = par_bit_of(1, 9'h041);
        send_frame(1, 9'h041, pb, 2'b11);
        check_frame("t3a", 1, 9'h041, pb, 2'b11);
        clr_pulse("t3a_clr", 1);
        send_frame(1, 9'h041, ~pb, 2'b11);
        check_frame("t3b", 1, 9'h041, ~pb, 2'b11);
        clr_pulse("t3b_clr", 1);

        // bad stop bit followed by a held-low line (break)
        send_frame(0, 9'h096, 1'b0, 2'b10);
        check_frame("t4_brk", 0, 9'h096, 1'b0, 2'b10);
        clr_pulse("t4_clr", 0);
        repeat (3 * bd_of(0)) @(negedge clk);
        check("t4_no_retrig", 32'(flags_of(0)), 32'd0);
        rx[0] = 1'b1;
        repeat (bd_of(0)) @(negedge clk);
        send_frame(0, 9'h03C, 1'b0, 2'b11);
        check_frame("t4_clean", 0, 9'h03C, 1'b0, 2'b11);
        clr_pulse("t4_clean_clr", 0);

        // overrun, then clr_rdy landing exactly on the commit cycle
        send_frame(0, 9'h011, 1'b0, 2'b11);
        check_frame("t5a", 0, 9'h011, 1'b0, 2'b11);
        send_frame(0, 9'h022, 1'b0, 2'b11);
        check_frame("t5b", 0, 9'h022, 1'b0, 2'b11);
        fork
            send_frame(0, 9'h033, 1'b0, 2'b11);
            begin
                repeat (lat_of(0)) @(posedge clk);
                @(negedge clk);
                clr[0] = 1'b1;
                @(posedge clk);
                #1;
                check("t5_commit_clr", 32'({rdyv[0], ovrv[0]}), 32'b10);
                @(negedge clk);
                clr[0] = 1'b0;
            end
        join
        rdy_m[0] = 1'b0;
        ovr_m[0] = 1'b0;
        check_frame("t5c", 0, 9'h033, 1'b0, 2'b11);
        clr_pulse("t5_clr", 0);

        // two stop bits, second one low
        send_frame(2, 9'h05A, 1'b0, 2'b01);
        check_frame("t6_stop2", 2, 9'h05A, 1'b0, 2'b01);
        rx[2] = 1'b1;
        repeat (bd_of(2)) @(negedge clk);

        // asynchronous reset in the middle of a data bit sequence
        rx[2] = 1'b0;
        repeat (bd_of(2)) @(negedge clk);
        rx[2] = 1'b1;
        repeat (bd_of(2)) @(negedge clk);
        rx[2] = 1'b0;
        repeat (bd_of(2) / 2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t6_rst_flags", 32'(flags_of(2)), 32'd0);
        check("t6_rst_data", 32'(data_of(2)), 32'd0);
        rdy_m = '0;
        ovr_m = '0;
        rx[2] = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12 * bd_of(2)) @(negedge clk);
        check("t6_post_flags", 32'(flags_of(2)), 32'd0);
        check("t6_post_data", 32'(data_of(2)), 32'd0);

        // random frames on every configuration
        for (int i = 0; i < 3; i++) begin
            for (int n = 0; n < 8; n++) begin
                d  = 9'($urandom) & mask_of(i);
                pb = par_bit_of(i, d) ^ ($urandom_range(0, 3) == 0);
                sv = {($urandom_range(0, 4) != 0), ($urandom_range(0, 4) != 0)};
                send_frame(i, d, pb, sv);
                check_frame($sformatf("rnd%0d_%0d", i, n), i, d, pb, sv);
                rx[i] = 1'b1;
                repeat (4 + $urandom_range(0, bd_of(i))) @(negedge clk);
                if ($urandom_range(0, 1) == 1) clr_pulse($sformatf("rnd%0d_%0d_clr", i, n), i);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
